// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and packing helpers for the multi-port register file.
// Flattened port buses place port p at bit offset p*width.
package regfile_pkg;

  localparam int REG_COUNT_DEF = 32;
  localparam int REG_W_DEF     = 32;
  localparam int RD_PORTS_MAX  = 4;
  localparam int WR_PORTS_MAX  = 3;

  // Index width, never less than one bit so a 1-entry file still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of port `port` inside a flattened bus of `width`-bit lanes.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_busy_scoreboard.sv
// Per-register busy bits: reserve sets, write clears, set wins on collision.
// Exposes the next-state busy of each read index and a registered popcount.
module busy_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int REG_IDX_W = idx_w(REG_COUNT),
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int ZERO_REG  = 1,
  parameter int CNT_W     = $clog2(REG_COUNT + 1)
) (
  input  logic                          clk_i,
  input  logic                          aresetn_i,
  input  logic [WR_PORTS-1:0]           wr_en_i,
  input  logic [WR_PORTS*REG_IDX_W-1:0] wr_reg_i,
  input  logic                          rsv_en_i,
  input  logic [REG_IDX_W-1:0]          rsv_reg_i,
  input  logic [RD_PORTS*REG_IDX_W-1:0] rd_reg_i,
  output logic [RD_PORTS-1:0]           rd_busy_nxt_o,
  output logic [CNT_W-1:0]              busy_count_o
);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  always_comb begin
    busy_d = busy_q;
    for (int q = 0; q < WR_PORTS; q++) begin
      if (wr_en_i[q] &&
          int'(wr_reg_i[slice_lo(q, REG_IDX_W) +: REG_IDX_W]) < REG_COUNT) begin
        busy_d[wr_reg_i[slice_lo(q, REG_IDX_W) +: REG_IDX_W]] = 1'b0;
      end
    end
    // Reserve applied after clears: a new producer outranks the retiring one.
    if (rsv_en_i && int'(rsv_reg_i) < REG_COUNT) begin
      busy_d[rsv_reg_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_comb begin
    rd_busy_nxt_o = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (int'(rd_reg_i[slice_lo(p, REG_IDX_W) +: REG_IDX_W]) < REG_COUNT) begin
        rd_busy_nxt_o[p] = busy_d[rd_reg_i[slice_lo(p, REG_IDX_W) +: REG_IDX_W]];
      end
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_count_o = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with registered reads, write-through bypass,
// optional hardwired x0 and a busy scoreboard for issue stalls.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int REG_W     = REG_W_DEF,
  parameter int REG_IDX_W = idx_w(REG_COUNT),
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [RD_PORTS*REG_IDX_W-1:0]   rd_reg,
  output logic [RD_PORTS*REG_W-1:0]       rd_data,
  output logic [RD_PORTS-1:0]             rd_busy,
  input  logic [WR_PORTS-1:0]             wr_en,
  input  logic [WR_PORTS*REG_IDX_W-1:0]   wr_reg,
  input  logic [WR_PORTS*REG_W-1:0]       wr_data,
  input  logic                            rsv_en,
  input  logic [REG_IDX_W-1:0]            rsv_reg,
  output logic [$clog2(REG_COUNT+1)-1:0]  busy_count
);

  localparam int CNT_W = $clog2(REG_COUNT + 1);

  logic [REG_W-1:0]          mem_q [REG_COUNT];
  logic [REG_W-1:0]          mem_d [REG_COUNT];
  logic [RD_PORTS*REG_W-1:0] rd_data_q, rd_data_d;
  logic [RD_PORTS-1:0]       rd_busy_q, rd_busy_d;

  function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx);
    return (int'(idx) < REG_COUNT) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  // Ports applied in ascending order so the highest-numbered writer lands last.
  // Reads then look at the post-write array, which gives the bypass for free.
  always_comb begin
    mem_d = mem_q;
    for (int q = 0; q < WR_PORTS; q++) begin
      if (wr_en[q] && idx_ok(wr_reg[slice_lo(q, REG_IDX_W) +: REG_IDX_W])) begin
        mem_d[wr_reg[slice_lo(q, REG_IDX_W) +: REG_IDX_W]] =
          wr_data[slice_lo(q, REG_W) +: REG_W];
      end
    end
    rd_data_d = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (idx_ok(rd_reg[slice_lo(p, REG_IDX_W) +: REG_IDX_W])) begin
        rd_data_d[slice_lo(p, REG_W) +: REG_W] =
          mem_d[rd_reg[slice_lo(p, REG_IDX_W) +: REG_IDX_W]];
      end
    end
  end

  busy_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .REG_IDX_W (REG_IDX_W),
    .RD_PORTS  (RD_PORTS),
    .WR_PORTS  (WR_PORTS),
    .ZERO_REG  (ZERO_REG),
    .CNT_W     (CNT_W)
  ) u_sb (
    .clk_i         (clk),
    .aresetn_i     (aresetn),
    .wr_en_i       (wr_en),
    .wr_reg_i      (wr_reg),
    .rsv_en_i      (rsv_en),
    .rsv_reg_i     (rsv_reg),
    .rd_reg_i      (rd_reg),
    .rd_busy_nxt_o (rd_busy_d),
    .busy_count_o  (busy_count)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

endmodule
